// File: rtl/pc_sequencer.sv
// Program-counter source unit: resolves branch/jump conditions, owns the PC and EPC,
// and sequences the IF/ID flush that follows every redirect.
module pc_sequencer #(
    parameter int                ADDR_W       = 32,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
    parameter logic [ADDR_W-1:0] EXC_VECTOR   = ADDR_W'('h180),
    parameter int                FLUSH_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic [2:0]        pc_source,
    input  logic              zero_flag,
    input  logic              neg_flag,
    input  logic [ADDR_W-1:0] branch_offset,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic [ADDR_W-1:0] reg_target,
    input  logic              exception,
    input  logic              eret,
    output logic [ADDR_W-1:0] pc_out,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic [ADDR_W-1:0] epc,
    output logic              branch_taken,
    output logic              flush,
    output logic              misaligned
);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    localparam logic [2:0] SRC_SEQ  = 3'b000;
    localparam logic [2:0] SRC_BEQ  = 3'b001;
    localparam logic [2:0] SRC_BNE  = 3'b010;
    localparam logic [2:0] SRC_BLEZ = 3'b011;
    localparam logic [2:0] SRC_BGTZ = 3'b100;
    localparam logic [2:0] SRC_J    = 3'b101;
    localparam logic [2:0] SRC_JR   = 3'b110;

    localparam int         RELOAD_I   = (FLUSH_CYCLES > 0) ? FLUSH_CYCLES - 1 : 0;
    localparam logic [2:0] CNT_RELOAD = 3'(RELOAD_I);
    localparam bit         HAS_FLUSH  = (FLUSH_CYCLES > 0);

    state_t            r_state, w_state_next;
    logic [2:0]        r_cnt, w_cnt_next;
    logic [ADDR_W-1:0] r_pc, w_pc_next;
    logic [ADDR_W-1:0] r_epc, w_epc_next;
    logic              r_bt, w_bt_next;
    logic              r_mis, w_mis_next;

    logic [ADDR_W-1:0] w_pc_plus4;
    logic [ADDR_W-1:0] w_target;
    logic              w_taken;
    logic              w_jr_mis;
    logic              w_redirect;

    assign w_pc_plus4 = r_pc + ADDR_W'(4);
    assign w_jr_mis   = (pc_source == SRC_JR) && (reg_target[1:0] != 2'b00);

    always_comb begin
        w_taken = 1'b0;
        case (pc_source)
            SRC_BEQ:  w_taken = zero_flag;
            SRC_BNE:  w_taken = !zero_flag;
            SRC_BLEZ: w_taken = zero_flag | neg_flag;
            SRC_BGTZ: w_taken = !zero_flag & !neg_flag;
            SRC_J:    w_taken = 1'b1;
            SRC_JR:   w_taken = 1'b1;
            default:  w_taken = 1'b0;   // seq and reserved encoding
        endcase
    end

    always_comb begin
        w_target = w_pc_plus4 + branch_offset;
        case (pc_source)
            SRC_J:   w_target = jump_target;
            SRC_JR:  w_target = reg_target;
            default: w_target = w_pc_plus4 + branch_offset;
        endcase
    end

    // Redirect priority: exception > eret > misaligned jr > taken redirect > sequential.
    // Exceptions bypass stall; everything else waits for an unstalled cycle.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_pc_next    = r_pc;
        w_epc_next   = r_epc;
        w_bt_next    = 1'b0;
        w_mis_next   = 1'b0;
        w_redirect   = 1'b0;

        if (exception) begin
            w_epc_next = r_pc;
            w_pc_next  = EXC_VECTOR;
            w_redirect = 1'b1;
        end else if (!stall) begin
            if (eret) begin
                w_pc_next  = r_epc;
                w_redirect = 1'b1;
            end else if (r_state == ST_RUN && w_jr_mis) begin
                w_epc_next = r_pc;
                w_pc_next  = EXC_VECTOR;
                w_mis_next = 1'b1;
                w_redirect = 1'b1;
            end else if (r_state == ST_RUN && w_taken) begin
                w_pc_next  = w_target;
                w_bt_next  = 1'b1;
                w_redirect = 1'b1;
            end else begin
                w_pc_next = w_pc_plus4;
                if (r_state == ST_FLUSH) begin
                    if (r_cnt == 3'd0) begin
                        w_state_next = ST_RUN;
                    end else begin
                        w_cnt_next = r_cnt - 3'd1;
                    end
                end
            end
        end

        if (w_redirect && HAS_FLUSH) begin
            w_state_next = ST_FLUSH;
            w_cnt_next   = CNT_RELOAD;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
            r_cnt   <= 3'd0;
            r_pc    <= RESET_VECTOR;
            r_epc   <= '0;
            r_bt    <= 1'b0;
            r_mis   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_pc    <= w_pc_next;
            r_epc   <= w_epc_next;
            r_bt    <= w_bt_next;
            r_mis   <= w_mis_next;
        end
    end

    assign pc_out       = r_pc;
    assign pc_plus4     = w_pc_plus4;
    assign epc          = r_epc;
    assign branch_taken = r_bt;
    assign flush        = (r_state == ST_FLUSH);
    assign misaligned   = r_mis;

    // Unused encoding constant kept next to its siblings for readability of the case tables.
    logic w_unused_seq;
    assign w_unused_seq = (pc_source == SRC_SEQ);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed-vector bench for pc_sequencer (RESET_VECTOR='h400, EXC_VECTOR='h180, FLUSH_CYCLES=2).
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic [2:0]  pc_source;
    logic        zero_flag;
    logic        neg_flag;
    logic [31:0] branch_offset;
    logic [31:0] jump_target;
    logic [31:0] reg_target;
    logic        exception;
    logic        eret;
    logic [31:0] pc_out;
    logic [31:0] pc_plus4;
    logic [31:0] epc;
    logic        branch_taken;
    logic        flush;
    logic        misaligned;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    pc_sequencer #(
        .ADDR_W       (32),
        .RESET_VECTOR (32'h400),
        .EXC_VECTOR   (32'h180),
        .FLUSH_CYCLES (2)
    ) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .pc_source     (pc_source),
        .zero_flag     (zero_flag),
        .neg_flag      (neg_flag),
        .branch_offset (branch_offset),
        .jump_target   (jump_target),
        .reg_target    (reg_target),
        .exception     (exception),
        .eret          (eret),
        .pc_out        (pc_out),
        .pc_plus4      (pc_plus4),
        .epc           (epc),
        .branch_taken  (branch_taken),
        .flush         (flush),
        .misaligned    (misaligned)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs === exp_v) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h, expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic exp_out(input string tag, input logic [31:0] p, input logic fl,
                           input logic bt, input logic mi);
        $display("txn %-10s pc=%h flush=%b taken=%b mis=%b epc=%h", tag, pc_out, flush,
                 branch_taken, misaligned, epc);
        chk({tag, ".pc"},    pc_out, p);
        chk({tag, ".flush"}, 32'(flush), 32'(fl));
        chk({tag, ".taken"}, 32'(branch_taken), 32'(bt));
        chk({tag, ".mis"},   32'(misaligned), 32'(mi));
    endtask

    task automatic idle();
        stall = 0; pc_source = 3'b000; zero_flag = 0; neg_flag = 0;
        branch_offset = 0; jump_target = 0; reg_target = 0; exception = 0; eret = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Jump, then let the two flush cycles drain; leaves pc at addr+8 in RUN.
    task automatic jump_to(input logic [31:0] addr);
        idle(); pc_source = 3'b101; jump_target = addr;
        tick(); exp_out("jmp", addr, 1, 1, 0);
        idle();
        tick(); exp_out("jmp.f1", addr + 32'd4, 1, 0, 0);
        tick(); exp_out("jmp.f2", addr + 32'd8, 0, 0, 0);
    endtask

    initial begin
        rst_n = 0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        exp_out("reset", 32'h400, 0, 0, 0);
        chk("reset.epc", epc, 32'h0);
        #2 rst_n = 1;

        // sequential fetch from reset vector
        tick(); exp_out("seq1", 32'h404, 0, 0, 0);
        tick(); exp_out("seq2", 32'h408, 0, 0, 0);
        tick(); exp_out("seq3", 32'h40C, 0, 0, 0);
        chk("seq.plus4", pc_plus4, 32'h410);

        jump_to(32'hF8);  // pc = 'h100

        // beq taken: 'h104 + 'h20
        idle(); pc_source = 3'b001; zero_flag = 1; branch_offset = 32'h20;
        tick(); exp_out("beq.t", 32'h124, 1, 1, 0);
        idle(); pc_source = 3'b001; zero_flag = 1; branch_offset = 32'h40;  // ignored in FLUSH
        tick(); exp_out("beq.f1", 32'h128, 1, 0, 0);
        tick(); exp_out("beq.f2", 32'h12C, 0, 0, 0);
        idle(); pc_source = 3'b001; zero_flag = 0; branch_offset = 32'h20;
        tick(); exp_out("beq.nt", 32'h130, 0, 0, 0);

        idle(); pc_source = 3'b100; neg_flag = 1; branch_offset = 32'h40;
        tick(); exp_out("bgtz.nt", 32'h134, 0, 0, 0);
        idle(); pc_source = 3'b011; neg_flag = 1; branch_offset = 32'h10;
        tick(); exp_out("blez.t", 32'h148, 1, 1, 0);
        idle();
        tick(); tick(); exp_out("blez.f2", 32'h150, 0, 0, 0);
        idle(); pc_source = 3'b010; zero_flag = 1; branch_offset = 32'h40;
        tick(); exp_out("bne.nt", 32'h154, 0, 0, 0);
        idle(); pc_source = 3'b111; zero_flag = 1; branch_offset = 32'h40;
        tick(); exp_out("rsvd", 32'h158, 0, 0, 0);

        // branch wrap-around at top of address space
        jump_to(32'hFFFF_FFF4);
        chk("wrap.plus4", pc_plus4, 32'h0);
        idle(); pc_source = 3'b001; zero_flag = 1; branch_offset = 32'h8;
        tick(); exp_out("wrap.br", 32'h8, 1, 1, 0);
        idle(); tick(); tick();
        exp_out("wrap.f2", 32'h10, 0, 0, 0);

        // misaligned jr then eret
        jump_to(32'h48);
        idle(); pc_source = 3'b110; reg_target = 32'h203;
        tick(); exp_out("jr.mis", 32'h180, 1, 0, 1);
        chk("jr.epc", epc, 32'h50);
        idle();
        tick(); exp_out("jr.f1", 32'h184, 1, 0, 0);
        tick(); exp_out("jr.f2", 32'h188, 0, 0, 0);
        idle(); eret = 1;
        tick(); exp_out("eret", 32'h50, 1, 0, 0);
        idle(); tick(); tick();
        exp_out("eret.f2", 32'h58, 0, 0, 0);
        idle(); pc_source = 3'b110; reg_target = 32'h300;
        tick(); exp_out("jr.ok", 32'h300, 1, 1, 0);
        chk("jr.ok.epc", epc, 32'h50);
        idle(); tick(); tick();

        // stall during flush
        idle(); pc_source = 3'b101; jump_target = 32'h500;
        tick(); exp_out("stj", 32'h500, 1, 1, 0);
        idle(); stall = 1; pc_source = 3'b101; jump_target = 32'h900;
        tick(); exp_out("stall1", 32'h500, 1, 0, 0);
        tick(); exp_out("stall2", 32'h500, 1, 0, 0);
        tick(); exp_out("stall3", 32'h500, 1, 0, 0);
        idle();
        tick(); exp_out("rel1", 32'h504, 1, 0, 0);
        tick(); exp_out("rel2", 32'h508, 0, 0, 0);
        idle(); stall = 1; pc_source = 3'b101; jump_target = 32'h900;
        tick(); exp_out("stall.run", 32'h508, 0, 0, 0);

        // exception while stalled mid-flush reloads the counter
        idle(); pc_source = 3'b101; jump_target = 32'h600;
        tick(); idle(); tick();
        exp_out("exf", 32'h604, 1, 0, 0);
        stall = 1; exception = 1;
        tick(); exp_out("exc.st", 32'h180, 1, 0, 0);
        chk("exc.epc", epc, 32'h604);
        idle();
        tick(); exp_out("exc.f1", 32'h184, 1, 0, 0);
        tick(); exp_out("exc.f2", 32'h188, 0, 0, 0);

        // exception and eret together: exception wins
        idle(); exception = 1; eret = 1;
        tick(); exp_out("exc+eret", 32'h180, 1, 0, 0);
        chk("exc+eret.epc", epc, 32'h188);
        idle(); stall = 1; eret = 1;
        tick(); exp_out("eret.st", 32'h180, 1, 0, 0);
        idle(); eret = 1;
        tick(); exp_out("eret2", 32'h188, 1, 0, 0);
        idle();
        tick(); exp_out("eret2.f1", 32'h18C, 1, 0, 0);
        tick(); exp_out("eret2.f2", 32'h190, 0, 0, 0);

        // asynchronous reset mid-flush
        idle(); pc_source = 3'b101; jump_target = 32'h700;
        tick(); exp_out("rstj", 32'h700, 1, 1, 0);
        idle();
        rst_n = 0;
        #2;
        exp_out("arst", 32'h400, 0, 0, 0);
        chk("arst.epc", epc, 32'h0);
        rst_n = 1;
        tick(); exp_out("arst.seq", 32'h404, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Next-generation program-counter source unit. It resolves the branch or jump condition, as the existing source-select logic does, and also owns the PC register itself.
- Adds the following over the existing unit:
  - parametrised address width;
  - extended branch set (blez/bgtz);
  - jr and exception/eret redirection;
  - pipeline stall;
  - multi-cycle flush sequencing after any redirect.
- Sits between the control unit / ALU flags and instruction fetch. Drives the fetch address and the flush to the IF/ID register.

Parameters:
- ADDR_W, 32, PC and target width in bits (>= 8).
- RESET_VECTOR, 0, PC value loaded on reset.
- EXC_VECTOR, 'h180, PC value loaded on exception or misaligned jr.
- FLUSH_CYCLES, 1, cycles flush is held after a redirect (0..7; 0 = no flush state).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  hold PC and flush counter this cycle.
- pc_source  in  3  000 seq, 001 beq, 010 bne, 011 blez, 100 bgtz, 101 j/jal, 110 jr, 111 reserved (treated as seq).
- zero_flag  in  1  ALU result == 0.
- neg_flag  in  1  ALU result < 0 (signed).
- branch_offset  in  ADDR_W  sign-extended, already <<2.
- jump_target  in  ADDR_W  absolute j/jal target.
- reg_target  in  ADDR_W  jr register value.
- exception  in  1  synchronous exception request.
- eret  in  1  return from exception.
- pc_out  out  ADDR_W  current fetch PC (registered).
- pc_plus4  out  ADDR_W  pc_out+4 mod 2^ADDR_W (combinational, used as jal link).
- epc  out  ADDR_W  saved exception PC (registered).
- branch_taken  out  1  registered one-cycle pulse after a taken redirect.
- flush  out  1  high while in FLUSH state.
- misaligned  out  1  registered one-cycle pulse when a jr target has bits[1:0] != 0.

Behaviour:
- Reset (asynchronous, rst_n=0), effective immediately:
  - pc_out=RESET_VECTOR, epc=0;
  - branch_taken=0, flush=0, misaligned=0;
  - state=RUN, flush counter=0.
- Taken conditions:
  - beq: zero_flag.
  - bne: !zero_flag.
  - blez: zero_flag|neg_flag.
  - bgtz: !zero_flag&!neg_flag.
  - j/jal and jr: always taken.
- Redirect targets:
  - Branch target = pc_plus4 + branch_offset, truncated to ADDR_W (wrap-around allowed, no error).
  - j/jal target = jump_target.
  - jr target = reg_target.
- Priority per clock edge, highest first:
  1. exception: epc<=pc_out, pc<=EXC_VECTOR. Honoured even when stall=1 and in any state.
  2. eret: pc<=epc. Honoured only when stall=0.
  3. misaligned jr (stall=0, state RUN): treated as exception. epc<=pc_out, pc<=EXC_VECTOR, misaligned pulses.
  4. taken redirect (stall=0, state RUN): pc<=target, branch_taken pulses.
  5. otherwise, stall=0: pc<=pc_plus4. stall=1: pc holds.
- States:
  - RUN:
    - any of items 1–4 with FLUSH_CYCLES>0 -> FLUSH, counter<=FLUSH_CYCLES-1.
    - with FLUSH_CYCLES=0, stay in RUN.
  - FLUSH:
    - flush=1; pc_source is ignored and sequential fetch continues (pc+4 unless stall).
    - counter decrements on each non-stalled cycle.
    - counter==0 and not stalled -> RUN.
    - exception or eret in FLUSH reloads the counter to FLUSH_CYCLES-1 and redirects as above.
- Latency: one cycle from decision inputs to pc_out; flush rises on the same edge pc_out changes.
- branch_taken and misaligned are each high for exactly one cycle and never simultaneously.
- stall=1 freezes state, counter and pc. Pulses deassert.
- Simultaneous exception+eret: exception wins, epc<=pc_out.

Test Plan:
- Reset with RESET_VECTOR='h400, then 3 unstalled seq cycles -> pc_out 'h400, 'h404, 'h408, 'h40C. flush=0.
- pc_out='h100, pc_source=001, zero_flag=1, branch_offset='h20 -> next pc='h124, branch_taken pulse, flush=1 for FLUSH_CYCLES cycles. With zero_flag=0 -> pc='h104, no flush.
- bgtz with neg_flag=1 -> not taken. blez with neg_flag=1 -> taken. Branch at pc='hFFFF_FFFC with offset 'h8 -> pc='h0000_0008 (wrap).
- jr with reg_target='h203 at pc='h50 -> pc=EXC_VECTOR, epc='h50, misaligned pulse. Then eret -> pc='h50.
- stall=1 for 3 cycles during FLUSH (FLUSH_CYCLES=2) -> pc and flush hold. Flush ends 2 unstalled cycles after release.
- Exception asserted with stall=1 mid-flush -> pc=EXC_VECTOR next edge, counter reloaded. rst_n dropped mid-flush -> immediate reset values.
